// File: rtl/icache_controller.sv
// icache_controller: sequencer for a direct-mapped instruction cache whose tag and data arrays
// live outside this block (combinational-read CacheMem arrays). Hits are resolved in the same
// cycle. A miss refills the whole line word-by-word from main memory, then writes the tag.
// Valid bits are held here so that reset and flush can invalidate every line at once.
//
// Ports:
//   i_clock, i_reset_n              clock (rising edge), asynchronous active-low reset
//   i_req, i_addr, i_flush          CPU fetch request, byte address, invalidate-all
//   o_hit, o_busy, o_data           hit this cycle, refill in progress, fetched word
//   o_mem_req, o_mem_addr           memory word request and word-aligned address
//   i_mem_ack, i_mem_data           memory word valid and its data
//   o_tag_wr/addr/wdata, i_tag_rdata  tag array write port and combinational read data
//   o_dat_wr/addr/wdata, i_dat_rdata  data array write port and combinational read data
module icache_controller #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned BLOCK_WIDTH = 2,
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH - 2
) (
  input  logic                               i_clock,
  input  logic                               i_reset_n,
  input  logic                               i_req,
  input  logic [ADDR_WIDTH-1:0]              i_addr,
  input  logic                               i_flush,
  output logic                               o_hit,
  output logic                               o_busy,
  output logic [DATA_WIDTH-1:0]              o_data,
  output logic                               o_mem_req,
  output logic [ADDR_WIDTH-1:0]              o_mem_addr,
  input  logic                               i_mem_ack,
  input  logic [DATA_WIDTH-1:0]              i_mem_data,
  output logic                               o_tag_wr,
  output logic [INDEX_WIDTH-1:0]             o_tag_addr,
  output logic [TAG_WIDTH-1:0]               o_tag_wdata,
  input  logic [TAG_WIDTH-1:0]               i_tag_rdata,
  output logic                               o_dat_wr,
  output logic [INDEX_WIDTH+BLOCK_WIDTH-1:0] o_dat_addr,
  output logic [DATA_WIDTH-1:0]              o_dat_wdata,
  input  logic [DATA_WIDTH-1:0]              i_dat_rdata
);

  localparam int unsigned NumLines = 2 ** INDEX_WIDTH;
  localparam logic [BLOCK_WIDTH-1:0] LastWord = {BLOCK_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StFill, StUpdate} state_e;

  state_e                 state_q;
  logic [NumLines-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]   line_tag_q;
  logic [INDEX_WIDTH-1:0] line_index_q;
  logic [BLOCK_WIDTH-1:0] count_q;
  logic                   flush_pend_q;
  logic                   mem_req_q;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [BLOCK_WIDTH-1:0] req_word;
  logic                   line_match;
  logic                   miss_start;
  logic                   ack_ok;
  logic                   unused_addr;

  assign req_tag     = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index   = i_addr[BLOCK_WIDTH+2 +: INDEX_WIDTH];
  assign req_word    = i_addr[2 +: BLOCK_WIDTH];
  // Byte offset within the word is irrelevant for instruction fetch.
  assign unused_addr = ^i_addr[1:0];

  assign line_match = valid_q[req_index] & (i_tag_rdata == req_tag);
  // Flush wins over a same-cycle lookup: no hit and no refill is started.
  assign miss_start = (state_q == StIdle) & i_req & ~line_match & ~i_flush;
  // An ack only counts while a request is outstanding.
  assign ack_ok     = (state_q == StFill) & mem_req_q & i_mem_ack;

  always_comb begin
    o_hit       = (state_q == StIdle) & i_req & line_match & ~i_flush;
    o_busy      = (state_q != StIdle);
    o_data      = i_dat_rdata;
    o_mem_req   = mem_req_q;
    o_mem_addr  = {line_tag_q, line_index_q, count_q, 2'b00};
    o_tag_wr    = (state_q == StUpdate);
    o_tag_addr  = (state_q == StUpdate) ? line_index_q : req_index;
    o_tag_wdata = line_tag_q;
    o_dat_wr    = ack_ok;
    o_dat_addr  = (state_q == StFill) ? {line_index_q, count_q} : {req_index, req_word};
    o_dat_wdata = i_mem_data;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      line_tag_q   <= '0;
      line_index_q <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_flush) begin
            valid_q <= '0;
          end else if (miss_start) begin
            line_tag_q   <= req_tag;
            line_index_q <= req_index;
            count_q      <= '0;
            mem_req_q    <= 1'b1;
            state_q      <= StFill;
          end
        end
        StFill: begin
          if (i_flush) flush_pend_q <= 1'b1;
          if (ack_ok) begin
            // Drop the request for one cycle after every accepted word.
            mem_req_q <= 1'b0;
            count_q   <= count_q + 1'b1;
            if (count_q == LastWord) state_q <= StUpdate;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        StUpdate: begin
          // A flush seen during the refill discards the new line along with everything else.
          if (flush_pend_q || i_flush) valid_q <= '0;
          else                          valid_q[line_index_q] <= 1'b1;
          flush_pend_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
module tb_icache_controller;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned BW = 2;
  localparam int unsigned TW = AW - IW - BW - 2;

  logic          i_clock   = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_req     = 1'b0;
  logic [AW-1:0] i_addr    = '0;
  logic          i_flush   = 1'b0;
  logic          o_hit, o_busy, o_mem_req, o_tag_wr, o_dat_wr;
  logic [DW-1:0] o_data, o_dat_wdata, i_dat_rdata;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_data = '0;
  logic [IW-1:0] o_tag_addr;
  logic [TW-1:0] o_tag_wdata, i_tag_rdata;
  logic [IW+BW-1:0] o_dat_addr;

  // External tag/data arrays with combinational read.
  logic [TW-1:0] tag_arr [32];
  logic [DW-1:0] dat_arr [128];
  assign i_tag_rdata = tag_arr[o_tag_addr];
  assign i_dat_rdata = dat_arr[o_dat_addr];

  logic resp_ack  = 1'b0;
  logic stray_ack = 1'b0;
  assign i_mem_ack = resp_ack | stray_ack;

  // Reference model: which lines are present and with which tag.
  bit            ref_valid [32];
  logic [TW-1:0] ref_tag   [32];

  int          errors = 0;
  int          checks = 0;
  int          dat_wr_cnt = 0;
  int          stab_viol = 0;
  int          gap_viol = 0;
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  logic [AW-1:0] held_addr = '0;
  bit          have_addr = 0;
  logic [AW-1:0] mem_log [$];

  icache_controller dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_flush     (i_flush),
    .o_hit       (o_hit),
    .o_busy      (o_busy),
    .o_data      (o_data),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_tag_wr    (o_tag_wr),
    .o_tag_addr  (o_tag_addr),
    .o_tag_wdata (o_tag_wdata),
    .i_tag_rdata (i_tag_rdata),
    .o_dat_wr    (o_dat_wr),
    .o_dat_addr  (o_dat_addr),
    .o_dat_wdata (o_dat_wdata),
    .i_dat_rdata (i_dat_rdata)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5EED_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Array writes and accepted memory words, sampled with pre-edge values.
  always @(posedge i_clock) begin
    if (o_dat_wr) begin
      dat_arr[o_dat_addr] <= o_dat_wdata;
      dat_wr_cnt <= dat_wr_cnt + 1;
    end
    if (o_tag_wr) tag_arr[o_tag_addr] <= o_tag_wdata;
    if (o_mem_req && i_mem_ack) mem_log.push_back(o_mem_addr);
  end

  // Memory responder: acks after ack_delay waiting cycles, watches address stability and gap.
  always @(negedge i_clock) begin
    if (!i_reset_n) begin
      resp_ack  = 1'b0;
      wait_cnt  = 0;
      have_addr = 0;
    end else if (resp_ack) begin
      if (o_mem_req !== 1'b0) gap_viol++;
      resp_ack  = 1'b0;
      have_addr = 0;
    end else if (o_mem_req) begin
      if (have_addr && (o_mem_addr !== held_addr)) stab_viol++;
      held_addr = o_mem_addr;
      have_addr = 1;
      if (wait_cnt >= ack_delay) begin
        resp_ack   = 1'b1;
        i_mem_data = mem_word(o_mem_addr);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_valid[i] = 0;
  endtask

  task automatic do_flush();
    @(negedge i_clock);
    i_req   = 1'b0;
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    clear_model();
  endtask

  // One fetch; on a miss, follows the refill and expects a hit once idle again.
  task automatic fetch(input logic [31:0] a, input int unsigned delay);
    logic          exp_hit;
    logic [4:0]    idx;
    logic [TW-1:0] tg;
    logic [31:0]   base;
    logic [1:0]    wb;
    int            cyc, log0, wr0;
    idx  = a[8:4];
    tg   = a[31:9];
    base = {a[31:4], 4'h0};
    ack_delay = delay;
    @(negedge i_clock);
    i_req  = 1'b1;
    i_addr = a;
    #1;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    checks++;
    if (o_hit !== exp_hit) begin
      errors++;
      $display("FAIL fetch_hit addr=%h got=%b exp=%b", a, o_hit, exp_hit);
    end
    if (exp_hit) begin
      checks++;
      if (o_data !== mem_word(a)) begin
        errors++;
        $display("FAIL hit_data addr=%h got=%h exp=%h", a, o_data, mem_word(a));
      end
    end else begin
      log0 = mem_log.size();
      wr0  = dat_wr_cnt;
      cyc  = 0;
      @(posedge i_clock);
      while (cyc <= 500) begin
        @(negedge i_clock);
        if (!o_busy) break;
        cyc++;
      end
      #1;
      checks++;
      if (cyc != 4 * (int'(delay) + 2)) begin
        errors++;
        $display("FAIL miss_penalty addr=%h got=%0d exp=%0d", a, cyc, 4 * (int'(delay) + 2));
      end
      checks++;
      if (mem_log.size() - log0 != 4) begin
        errors++;
        $display("FAIL mem_req_count addr=%h got=%0d exp=4", a, mem_log.size() - log0);
      end else begin
        for (int w = 0; w < 4; w++) begin
          checks++;
          if (mem_log[log0 + w] !== base + 32'(4 * w)) begin
            errors++;
            $display("FAIL mem_addr word=%0d got=%h exp=%h", w, mem_log[log0 + w],
                     base + 32'(4 * w));
          end
        end
      end
      checks++;
      if (dat_wr_cnt - wr0 != 4) begin
        errors++;
        $display("FAIL dat_wr_count addr=%h got=%0d exp=4", a, dat_wr_cnt - wr0);
      end
      for (int w = 0; w < 4; w++) begin
        wb = w[1:0];
        checks++;
        if (dat_arr[{idx, wb}] !== mem_word(base + 32'(4 * w))) begin
          errors++;
          $display("FAIL line_data word=%0d got=%h exp=%h", w, dat_arr[{idx, wb}],
                   mem_word(base + 32'(4 * w)));
        end
      end
      ref_valid[idx] = 1;
      ref_tag[idx]   = tg;
      checks++;
      if (o_hit !== 1'b1) begin
        errors++;
        $display("FAIL refill_hit addr=%h got=%b exp=1", a, o_hit);
      end
      checks++;
      if (o_data !== mem_word(a)) begin
        errors++;
        $display("FAIL refill_data addr=%h got=%h exp=%h", a, o_data, mem_word(a));
      end
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) tag_arr[i] = '0;
    for (int i = 0; i < 128; i++) dat_arr[i] = '0;
    #3 i_reset_n = 1'b0;
    #1;
    checks += 5;
    if (o_hit !== 1'b0)     begin errors++; $display("FAIL reset_hit got=%b exp=0", o_hit); end
    if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", o_mem_req); end
    if (o_tag_wr !== 1'b0)  begin errors++; $display("FAIL reset_tag_wr got=%b exp=0", o_tag_wr); end
    if (o_dat_wr !== 1'b0)  begin errors++; $display("FAIL reset_dat_wr got=%b exp=0", o_dat_wr); end
    repeat (3) @(negedge i_clock);
    i_reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_fill_and_hit();
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0048, 0);
    checks++;
    @(negedge i_clock);
    i_req  = 1'b1;
    i_addr = 32'h0000_0048;
    #1;
    if (o_hit !== 1'b1 || o_data !== 32'hA2) begin
      errors++;
      $display("FAIL hit_0x48 got hit=%b data=%h exp hit=1 data=000000a2", o_hit, o_data);
    end
    i_req = 1'b0;
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0840, 0);
    fetch(32'h0000_0040, 0);
  endtask

  task automatic test_flush();
    do_flush();
    fetch(32'h0000_0044, 0);
    // Flush together with a request to a present line: no hit, no refill.
    @(negedge i_clock);
    i_req = 1'b1; i_addr = 32'h0000_0044; i_flush = 1'b1;
    #1;
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL flush_req_hit got=%b exp=0", o_hit); end
    @(negedge i_clock);
    i_req = 1'b0; i_flush = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_req_busy got=%b exp=0", o_busy); end
    clear_model();
    // Flush in the middle of a refill leaves that line invalid.
    ack_delay = 0;
    @(negedge i_clock);
    i_req = 1'b1; i_addr = 32'h0000_0048;
    @(negedge i_clock);
    i_req = 1'b0;
    repeat (2) @(negedge i_clock);
    i_flush = 1'b1;
    @(negedge i_clock);
    i_flush = 1'b0;
    for (int n = 0; n < 50 && o_busy; n++) @(negedge i_clock);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_fill_timeout got busy=%b exp=0", o_busy); end
    fetch(32'h0000_0048, 0);
  endtask

  task automatic test_stray_ack();
    int wr0;
    wr0 = dat_wr_cnt;
    @(negedge i_clock);
    stray_ack = 1'b1;
    #1;
    checks++;
    if (o_dat_wr !== 1'b0) begin errors++; $display("FAIL stray_ack_wr got=%b exp=0", o_dat_wr); end
    @(negedge i_clock);
    stray_ack = 1'b0;
    #1;
    checks++;
    if (dat_wr_cnt != wr0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_effect got writes=%0d busy=%b exp writes=0 busy=0",
               dat_wr_cnt - wr0, o_busy);
    end
  endtask

  task automatic test_slow_memory();
    fetch(32'h0000_1230, 5);
    fetch(32'h0000_1234, 0);
    checks += 2;
    if (stab_viol != 0) begin errors++; $display("FAIL req_stable got=%0d exp=0", stab_viol); end
    if (gap_viol != 0)  begin errors++; $display("FAIL req_gap got=%0d exp=0", gap_viol); end
  endtask

  task automatic test_reset_midfill();
    int log0, n;
    do_flush();
    ack_delay = 2;
    @(negedge i_clock);
    i_req = 1'b1; i_addr = 32'h0000_0040;
    @(negedge i_clock);
    i_req = 1'b0;
    log0 = mem_log.size();
    n = 0;
    while (mem_log.size() - log0 < 2 && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    checks++;
    if (mem_log.size() - log0 < 2) begin
      errors++;
      $display("FAIL midfill_progress got=%0d exp=2", mem_log.size() - log0);
    end
    @(posedge i_clock);
    #2;
    checks++;
    if (o_mem_req !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midfill_pre got req=%b busy=%b exp req=1 busy=1", o_mem_req, o_busy);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_dat_wr !== 1'b0 || o_tag_wr !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset got req=%b busy=%b dwr=%b twr=%b exp all 0",
               o_mem_req, o_busy, o_dat_wr, o_tag_wr);
    end
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    clear_model();
    fetch(32'h0000_0040, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int it = 0; it < 40; it++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge i_clock);
        i_req = 1'b1; i_addr = a; i_flush = 1'b1;
        #1;
        checks++;
        if (o_hit !== 1'b0) begin errors++; $display("FAIL rand_flush_hit got=%b exp=0", o_hit); end
        @(negedge i_clock);
        i_req = 1'b0; i_flush = 1'b0;
        clear_model();
      end else begin
        fetch(a, $urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_hit();
    test_conflict();
    test_flush();
    test_stray_ack();
    test_slow_memory();
    test_reset_midfill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
